// File: rtl/joy_pkg.sv
// Shared constants and types for the joystick shift-register scanner.
// Also holds the slot-to-bit map that de-scrambles the board wiring order.
package joy_pkg;

    localparam int NSLOTS          = 26;
    localparam int FIRST_DATA_SLOT = 2;
    localparam int NDATA           = 24;

    localparam int BIT_START   = 8;
    localparam int BIT_COIN    = 9;
    localparam int BIT_SERVICE = 10;
    localparam int BIT_RESET   = 11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMPARE} state_t;

    typedef struct packed {
        logic       player;
        logic [3:0] bit_idx;
    } slot_map_t;

    // Entry k describes the bit sampled in slot FIRST_DATA_SLOT + k
    localparam slot_map_t SLOT_MAP [NDATA] = '{
        '{1'b0, 4'd8},  '{1'b0, 4'd6},  '{1'b0, 4'd5},  '{1'b0, 4'd4},
        '{1'b0, 4'd3},  '{1'b0, 4'd2},  '{1'b0, 4'd1},  '{1'b0, 4'd0},
        '{1'b1, 4'd8},  '{1'b1, 4'd6},  '{1'b1, 4'd5},  '{1'b1, 4'd4},
        '{1'b1, 4'd3},  '{1'b1, 4'd2},  '{1'b1, 4'd1},  '{1'b1, 4'd0},
        '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd9},  '{1'b1, 4'd7},
        '{1'b0, 4'd10}, '{1'b0, 4'd11}, '{1'b0, 4'd9},  '{1'b0, 4'd7}
    };

    // Capture word layout: [11:0] = player 1, [23:12] = player 2
    function automatic logic [4:0] capture_index(input slot_map_t m);
        return m.player ? 5'(12 + int'(m.bit_idx)) : 5'(m.bit_idx);
    endfunction

endpackage

// File: rtl/joy_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
// Counter is held at zero while disabled so the next run starts aligned.
module joy_clk_div #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [7:0] div;

    assign tick = en && (div == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !en)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 8'd1;
    end

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick shift-register scanner: drives JOY_CLK/JOY_LOAD via clock enable,
// deserialises 24 bits per frame and publishes only two identical frames in a row.
module joy_scan_ctrl #(
    parameter int CLK_DIV = 16,
    parameter int NSLOTS  = joy_pkg::NSLOTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_valid,
    output logic        frame_err
);

    import joy_pkg::*;

    localparam int SLOT_W = $clog2(NSLOTS + 1);

    state_t            state, state_n;
    logic              tick, rise, slot_end, cnt_en, load_n;
    logic [SLOT_W-1:0] slot;
    logic [23:0]       capture, shadow;
    logic [4:0]        map_idx, cap_idx;

    assign cnt_en = (state == LOAD) || (state == SHIFT);

    joy_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .tick  (tick)
    );

    // joy_clk doubles as the half-slot phase: low half ends in rise, high half in slot_end
    assign rise     = tick && !joy_clk;
    assign slot_end = tick && joy_clk;
    assign map_idx  = 5'(slot - SLOT_W'(FIRST_DATA_SLOT));
    assign cap_idx  = capture_index(SLOT_MAP[map_idx]);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        load_n  = 1'b1;
        unique case (state)
            IDLE:    if (en) state_n = LOAD;
            LOAD:    if (slot_end) state_n = SHIFT;
            SHIFT:   if (slot_end && slot == SLOT_W'(NSLOTS - 1)) state_n = COMPARE;
            COMPARE: state_n = en ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n == LOAD)
            load_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            joy_clk     <= 1'b0;
            joy_load    <= 1'b1;
            slot        <= '0;
            capture     <= '1;
            shadow      <= '1;
            joystick1   <= 12'hFFF;
            joystick2   <= 12'hFFF;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            joy_load    <= load_n;

            if (!cnt_en)
                joy_clk <= 1'b0;
            else if (tick)
                joy_clk <= ~joy_clk;

            if (!cnt_en)
                slot <= '0;
            else if (slot_end)
                slot <= slot + SLOT_W'(1);

            // Preset to released so unsampled bits never read as pressed
            if (state_n == LOAD && state != LOAD)
                capture <= '1;
            else if (state == SHIFT && rise && slot >= SLOT_W'(FIRST_DATA_SLOT))
                capture[cap_idx] <= joy_data;

            if (state == COMPARE) begin
                shadow <= capture;
                if (capture == shadow) begin
                    joystick1   <= capture[11:0];
                    joystick2   <= capture[23:12];
                    frame_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl at CLK_DIV = 2 with a behavioural 74165-style chain model.
// Per-frame table of pin patterns and expected strobes/outputs, plus en-drop and reset sequences.
module tb_joy_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int FRAME   = 105;
    localparam int NVEC    = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        joy_data;
    logic        joy_clk, joy_load, frame_valid, frame_err;
    logic [11:0] joystick1, joystick2;
    logic [25:0] pre = '1;
    logic [25:0] sr  = '1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic        s1;
        logic        exp_valid;
        logic [11:0] exp_j1;
        logic [11:0] exp_j2;
    } vec_t;

    vec_t tbl [NVEC];

    joy_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .joy_data    (joy_data),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External chain: async parallel load while low, shift on JOY_CLK rise
    always @(posedge joy_clk or negedge joy_load) begin
        if (!joy_load)
            sr <= pre;
        else
            sr <= {sr[24:0], 1'b1};
    end
    assign joy_data = sr[25];

    // Bit 25 is seen in slot 1, bit 24 in slot 2, ..., bit 1 in slot 25
    function automatic logic [25:0] build_pre(input logic [11:0] j1, input logic [11:0] j2,
                                              input logic s1);
        return {s1, j1[8], j1[6], j1[5], j1[4], j1[3], j1[2], j1[1], j1[0],
                j2[8], j2[6], j2[5], j2[4], j2[3], j2[2], j2[1], j2[0],
                j2[10], j2[11], j2[9], j2[7], j1[10], j1[11], j1[9], j1[7], 1'b1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe(output bit got, output int at);
        got = 1'b0;
        at  = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got no strobe in 300 cycles, expected one");
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_load"}, 32'(joy_load), 32'd1);
        check({name, "_clk"}, 32'(joy_clk), 32'd0);
        check({name, "_j1"}, 32'(joystick1), 32'hFFF);
        check({name, "_j2"}, 32'(joystick2), 32'hFFF);
        check({name, "_strobes"}, 32'({frame_valid, frame_err}), 32'd0);
    endtask

    initial begin
        bit got;
        int at, last_at, low_cnt, rises, bad;
        logic prev;

        tbl[0]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b1, 12'hFFF, 12'hFFF};
        tbl[1]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b1, 12'hFFF, 12'hFFF};
        tbl[2]  = '{12'hFFE, 12'h7FF, 1'b1, 1'b0, 12'hFFF, 12'hFFF};
        tbl[3]  = '{12'hFFE, 12'h7FF, 1'b1, 1'b1, 12'hFFE, 12'h7FF};
        tbl[4]  = '{12'hFFE, 12'h7FF, 1'b0, 1'b1, 12'hFFE, 12'h7FF};
        tbl[5]  = '{12'hFFE, 12'h7FF, 1'b1, 1'b1, 12'hFFE, 12'h7FF};
        tbl[6]  = '{12'hFF0, 12'h7FF, 1'b1, 1'b0, 12'hFFE, 12'h7FF};
        tbl[7]  = '{12'hFFF, 12'h7FF, 1'b1, 1'b0, 12'hFFE, 12'h7FF};
        tbl[8]  = '{12'hFF0, 12'h7FF, 1'b1, 1'b0, 12'hFFE, 12'h7FF};
        tbl[9]  = '{12'hFFF, 12'h7FF, 1'b1, 1'b0, 12'hFFE, 12'h7FF};
        tbl[10] = '{12'hFFF, 12'h7FF, 1'b1, 1'b1, 12'hFFF, 12'h7FF};
        tbl[11] = '{12'hA5C, 12'h3C9, 1'b0, 1'b0, 12'hFFF, 12'h7FF};
        tbl[12] = '{12'hA5C, 12'h3C9, 1'b1, 1'b1, 12'hA5C, 12'h3C9};
        tbl[13] = '{12'h5A3, 12'hC36, 1'b1, 1'b0, 12'hA5C, 12'h3C9};
        tbl[14] = '{12'h5A3, 12'hC36, 1'b0, 1'b1, 12'h5A3, 12'hC36};

        pre   = build_pre(tbl[0].j1, tbl[0].j2, tbl[0].s1);
        reset = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        low_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!joy_load) break;
        end
        while (!joy_load && low_cnt < 20) begin
            low_cnt++;
            @(negedge clk);
        end
        check("first_load_len", low_cnt, 2 * CLK_DIV);

        last_at = 0;
        for (int i = 0; i < NVEC; i++) begin
            pre = build_pre(tbl[i].j1, tbl[i].j2, tbl[i].s1);
            wait_strobe(got, at);
            check($sformatf("v%0d_valid", i), 32'(frame_valid), 32'(tbl[i].exp_valid));
            check($sformatf("v%0d_err", i), 32'(frame_err), 32'(!tbl[i].exp_valid));
            check($sformatf("v%0d_j1", i), 32'(joystick1), 32'(tbl[i].exp_j1));
            check($sformatf("v%0d_j2", i), 32'(joystick2), 32'(tbl[i].exp_j2));
            if (i > 0)
                check($sformatf("v%0d_period", i), at - last_at, FRAME);
            last_at = at;
        end

        // Drop en at the start of slot 10: the frame must drain to COMPARE
        repeat (40) @(negedge clk);
        en    = 1'b0;
        prev  = joy_clk;
        rises = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (joy_clk && !prev) rises++;
            prev = joy_clk;
            if (frame_valid || frame_err) break;
        end
        check("drain_rises", rises, 16);
        check("drain_valid", 32'(frame_valid), 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (joy_clk !== 1'b0 || joy_load !== 1'b1 || frame_valid || frame_err) bad++;
        end
        check("idle_quiet", bad, 0);
        en = 1'b1;
        @(negedge clk);
        check("restart_load", 32'(joy_load), 32'd0);
        wait_strobe(got, at);
        check("restart_valid", 32'(frame_valid), 32'd1);
        check("restart_j1", 32'(joystick1), 32'h5A3);
        check("restart_j2", 32'(joystick2), 32'hC36);

        // Reset pulse during slot 15
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("midreset_reload", 32'(joy_load), 32'd0);
        wait_strobe(got, at);
        check("post_reset_err", 32'(frame_err), 32'd1);
        check("post_reset_j1", 32'(joystick1), 32'hFFF);
        check("post_reset_j2", 32'(joystick2), 32'hFFF);
        last_at = at;
        wait_strobe(got, at);
        check("post_reset_valid", 32'(frame_valid), 32'd1);
        check("post_reset_vj1", 32'(joystick1), 32'h5A3);
        check("post_reset_vj2", 32'(joystick2), 32'hC36);
        check("post_reset_period", at - last_at, FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
